// File: rtl/controle_varredura_matriz.sv
// ---------------------------------------------------------------------------
// controle_varredura_matriz
// Scan controller for a 7x5 LED matrix. Lights one row at a time. Each row's
// column pattern is fetched from an external pattern memory. A blanking gap
// follows every row to avoid ghosting. The displayed frame is chosen by the
// mode switches: off, fixed, auto-advance, or manual step by button.
//
// Ports
//   clock_50MHz   in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-high
//   chaves        in   2  mode: 00 off, 01 fixed, 10 auto, 11 manual (async)
//   botao         in   1  manual step button, active-high (async)
//   dado_colunas  in   5  pattern for (end_quadro, end_linha), 1 = LED on
//   end_quadro    out  3  frame address to the pattern memory
//   end_linha     out  3  row address to the pattern memory (0..6)
//   linhas        out  7  row drives, active-low, one-hot
//   colunas       out  5  column drives, active-low
//   fim_quadro    out  1  one-cycle pulse at each frame boundary
// ---------------------------------------------------------------------------
module controle_varredura_matriz #(
  parameter int DIV_LINHA    = 50000,
  parameter int APAGA        = 500,
  parameter int N_QUADROS    = 8,
  parameter int QUADROS_AUTO = 100
) (
  input  logic       clock_50MHz,
  input  logic       reset,
  input  logic [1:0] chaves,
  input  logic       botao,
  input  logic [4:0] dado_colunas,
  output logic [2:0] end_quadro,
  output logic [2:0] end_linha,
  output logic [6:0] linhas,
  output logic [4:0] colunas,
  output logic       fim_quadro
);

  localparam int MAXC = (DIV_LINHA > APAGA) ? DIV_LINHA : APAGA;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int FW   = $clog2(QUADROS_AUTO + 1);

  localparam logic [CW-1:0] C_FIM_EXIBE = CW'(DIV_LINHA - 1);
  localparam logic [CW-1:0] C_FIM_APAGA = CW'((APAGA > 0) ? (APAGA - 1) : 0);
  localparam logic [FW-1:0] C_QA        = FW'(QUADROS_AUTO);
  localparam logic [2:0]    C_ULT_Q     = 3'(N_QUADROS - 1);

  typedef enum logic [1:0] {
    DESLIGADO = 2'd0,
    CARREGA   = 2'd1,
    EXIBE     = 2'd2,
    APAGADO   = 2'd3
  } estado_t;

  // Synchronizers
  logic [1:0] r_chaves_s1, r_chaves_s2;
  logic       r_botao_s1, r_botao_s2, r_botao_ant, r_pendente;
  logic       w_borda;
  logic       w_consome;

  // Scan state and registered outputs
  estado_t       r_estado, w_estado_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_linha, w_linha_next;
  logic [FW-1:0] r_cont_q, w_cont_q_next;
  logic [2:0]    r_end_quadro, w_end_quadro_next;
  logic [6:0]    r_linhas, w_linhas_next;
  logic [4:0]    r_colunas, w_colunas_next;
  logic          r_fim, w_fim_next;
  logic          w_fim_linha;
  logic [2:0]    w_eq_avanca;

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      r_chaves_s1 <= 2'b00;
      r_chaves_s2 <= 2'b00;
    end else begin
      r_chaves_s1 <= chaves;
      r_chaves_s2 <= r_chaves_s1;
    end
  end

  assign w_borda = r_botao_s2 & ~r_botao_ant;

  // Button edge detector and step request. A request only lives in manual
  // mode. When the frame boundary consumes it, a press landing in that
  // same cycle is kept for the following frame.
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      r_botao_s1  <= 1'b0;
      r_botao_s2  <= 1'b0;
      r_botao_ant <= 1'b0;
      r_pendente  <= 1'b0;
    end else begin
      r_botao_s1  <= botao;
      r_botao_s2  <= r_botao_s1;
      r_botao_ant <= r_botao_s2;
      if (r_chaves_s2 != 2'b11) begin
        r_pendente <= 1'b0;
      end else if (w_consome) begin
        r_pendente <= w_borda;
      end else if (w_borda) begin
        r_pendente <= 1'b1;
      end
    end
  end

  assign w_eq_avanca = (r_end_quadro == C_ULT_Q) ? 3'd0 : (r_end_quadro + 3'd1);

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      r_estado     <= DESLIGADO;
      r_cnt        <= '0;
      r_linha      <= 3'd0;
      r_cont_q     <= '0;
      r_end_quadro <= 3'd0;
      r_linhas     <= 7'h7F;
      r_colunas    <= 5'h1F;
      r_fim        <= 1'b0;
    end else begin
      r_estado     <= w_estado_next;
      r_cnt        <= w_cnt_next;
      r_linha      <= w_linha_next;
      r_cont_q     <= w_cont_q_next;
      r_end_quadro <= w_end_quadro_next;
      r_linhas     <= w_linhas_next;
      r_colunas    <= w_colunas_next;
      r_fim        <= w_fim_next;
    end
  end

  always_comb begin
    w_estado_next     = r_estado;
    w_cnt_next        = r_cnt;
    w_linha_next      = r_linha;
    w_cont_q_next     = r_cont_q;
    w_end_quadro_next = r_end_quadro;
    w_linhas_next     = 7'h7F;
    w_colunas_next    = 5'h1F;
    w_fim_next        = 1'b0;
    w_consome         = 1'b0;
    w_fim_linha       = 1'b0;

    if (r_chaves_s2 == 2'b00) begin
      // Off overrides everything at once; the frame address is kept.
      w_estado_next = DESLIGADO;
      w_cnt_next    = '0;
      w_linha_next  = 3'd0;
      w_cont_q_next = '0;
    end else begin
      case (r_estado)
        DESLIGADO: begin
          w_estado_next = CARREGA;
          w_cnt_next    = '0;
          w_linha_next  = 3'd0;
        end
        CARREGA: begin
          // The address has been stable for this whole cycle, so the
          // memory data is valid at this edge.
          w_estado_next  = EXIBE;
          w_cnt_next     = '0;
          w_linhas_next  = ~(7'd1 << r_linha);
          w_colunas_next = ~dado_colunas;
        end
        EXIBE: begin
          w_linhas_next  = r_linhas;
          w_colunas_next = r_colunas;
          if (r_cnt == C_FIM_EXIBE) begin
            w_cnt_next     = '0;
            w_linhas_next  = 7'h7F;
            w_colunas_next = 5'h1F;
            if (APAGA == 0) begin
              w_fim_linha = 1'b1;
            end else begin
              w_estado_next = APAGADO;
            end
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        APAGADO: begin
          if (r_cnt == C_FIM_APAGA) begin
            w_fim_linha = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        default: w_estado_next = DESLIGADO;
      endcase

      if (w_fim_linha) begin
        w_estado_next = CARREGA;
        w_cnt_next    = '0;
        if (r_linha == 3'd6) begin
          // Frame boundary: the only place where the frame address moves.
          w_linha_next = 3'd0;
          w_fim_next   = 1'b1;
          case (r_chaves_s2)
            2'b10: begin
              if (r_cont_q + FW'(1) == C_QA) begin
                w_cont_q_next     = '0;
                w_end_quadro_next = w_eq_avanca;
              end else begin
                w_cont_q_next = r_cont_q + FW'(1);
              end
            end
            2'b11: begin
              w_cont_q_next = '0;
              w_consome     = 1'b1;
              if (r_pendente) begin
                w_end_quadro_next = w_eq_avanca;
              end
            end
            default: w_cont_q_next = '0;
          endcase
        end else begin
          w_linha_next = r_linha + 3'd1;
        end
      end
    end
  end

  assign end_quadro = r_end_quadro;
  assign end_linha  = r_linha;
  assign linhas     = r_linhas;
  assign colunas    = r_colunas;
  assign fim_quadro = r_fim;

endmodule

// File: tb/tb_controle_varredura_matriz.sv
// ---------------------------------------------------------------------------
// tb_controle_varredura_matriz
// Directed bench for the matrix scan controller with short timing
// (4-cycle rows, 2 blank cycles, 3 frames, auto step every 2 frames).
// The pattern memory returns {end_quadro[1:0], end_linha}, driven from the
// DUT's registered address outputs.
// ---------------------------------------------------------------------------
module tb_controle_varredura_matriz;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] chaves;
  logic       botao;
  logic [4:0] dado_colunas;
  logic [2:0] end_quadro;
  logic [2:0] end_linha;
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic       fim_quadro;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  controle_varredura_matriz #(
    .DIV_LINHA(4), .APAGA(2), .N_QUADROS(3), .QUADROS_AUTO(2)
  ) dut (
    .clock_50MHz (clk),
    .reset       (reset),
    .chaves      (chaves),
    .botao       (botao),
    .dado_colunas(dado_colunas),
    .end_quadro  (end_quadro),
    .end_linha   (end_linha),
    .linhas      (linhas),
    .colunas     (colunas),
    .fim_quadro  (fim_quadro)
  );

  assign dado_colunas = {end_quadro[1:0], end_linha};

  typedef struct {
    int         ciclo;
    logic [1:0] chaves;
    logic [6:0] linhas;
    logic [4:0] colunas;
    logic [2:0] eq;
    logic [2:0] el;
    logic       fim;
  } vetor_t;

  // Whole-run invariants: at most one row low, columns dark when no row lit.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_tests++;
      if ($countones(~linhas) > 1) begin
        n_fail++;
        $display("FAIL onehot: linhas=%h has more than one low bit", linhas);
      end
      n_tests++;
      if (linhas == 7'h7F && colunas != 5'h1F) begin
        n_fail++;
        $display("FAIL blank: colunas=%h while no row lit, required 1f", colunas);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nome, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nome, got, exp);
    end else begin
      $display("[TB] ok %s = %h", nome, got);
    end
  endtask

  task automatic wait_fim(input string nome);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(1);
      if (fim_quadro === 1'b1) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: fim_quadro not seen within 60 cycles, required a pulse", nome);
    end
  endtask

  initial begin
    vetor_t     tab[21];
    logic [2:0] exp10[6];
    int         idx;

    tab[0]  = '{2,   2'b01, 7'h7F, 5'h1F, 3'd0, 3'd0, 1'b0};
    tab[1]  = '{3,   2'b01, 7'h7F, 5'h1F, 3'd0, 3'd0, 1'b0};
    tab[2]  = '{4,   2'b01, 7'h7E, 5'h1F, 3'd0, 3'd0, 1'b0};
    tab[3]  = '{7,   2'b01, 7'h7E, 5'h1F, 3'd0, 3'd0, 1'b0};
    tab[4]  = '{8,   2'b01, 7'h7F, 5'h1F, 3'd0, 3'd0, 1'b0};
    tab[5]  = '{9,   2'b01, 7'h7F, 5'h1F, 3'd0, 3'd0, 1'b0};
    tab[6]  = '{10,  2'b01, 7'h7F, 5'h1F, 3'd0, 3'd1, 1'b0};
    tab[7]  = '{11,  2'b01, 7'h7D, 5'h1E, 3'd0, 3'd1, 1'b0};
    tab[8]  = '{18,  2'b01, 7'h7B, 5'h1D, 3'd0, 3'd2, 1'b0};
    tab[9]  = '{25,  2'b01, 7'h77, 5'h1C, 3'd0, 3'd3, 1'b0};
    tab[10] = '{28,  2'b01, 7'h77, 5'h1C, 3'd0, 3'd3, 1'b0};
    tab[11] = '{29,  2'b01, 7'h7F, 5'h1F, 3'd0, 3'd3, 1'b0};
    tab[12] = '{32,  2'b01, 7'h6F, 5'h1B, 3'd0, 3'd4, 1'b0};
    tab[13] = '{39,  2'b01, 7'h5F, 5'h1A, 3'd0, 3'd5, 1'b0};
    tab[14] = '{46,  2'b01, 7'h3F, 5'h19, 3'd0, 3'd6, 1'b0};
    tab[15] = '{51,  2'b01, 7'h7F, 5'h1F, 3'd0, 3'd6, 1'b0};
    tab[16] = '{52,  2'b01, 7'h7F, 5'h1F, 3'd0, 3'd0, 1'b1};
    tab[17] = '{53,  2'b01, 7'h7E, 5'h1F, 3'd0, 3'd0, 1'b0};
    tab[18] = '{60,  2'b01, 7'h7D, 5'h1E, 3'd0, 3'd1, 1'b0};
    tab[19] = '{101, 2'b01, 7'h7F, 5'h1F, 3'd0, 3'd0, 1'b1};
    tab[20] = '{150, 2'b01, 7'h7F, 5'h1F, 3'd0, 3'd0, 1'b1};

    exp10[0] = 3'd0; exp10[1] = 3'd1; exp10[2] = 3'd1;
    exp10[3] = 3'd2; exp10[4] = 3'd2; exp10[5] = 3'd0;

    // Reset state, mode 01 already selected
    reset  = 1'b1;
    chaves = 2'b01;
    botao  = 1'b0;
    step(2);
    chk("rst linhas", {1'b0, linhas}, 8'h7F);
    chk("rst colunas", {3'b0, colunas}, 8'h1F);
    chk("rst end_quadro", {5'b0, end_quadro}, 8'h00);
    chk("rst end_linha", {5'b0, end_linha}, 8'h00);
    chk("rst fim_quadro", {7'b0, fim_quadro}, 8'h00);
    reset = 1'b0;

    // Mode 01: three frames against the vector table
    idx = 0;
    for (int k = 1; k <= 150; k++) begin
      step(1);
      while (idx < 21 && tab[idx].ciclo == k) begin
        chaves = tab[idx].chaves;
        n_tests++;
        if (linhas !== tab[idx].linhas || colunas !== tab[idx].colunas ||
            end_quadro !== tab[idx].eq || end_linha !== tab[idx].el ||
            fim_quadro !== tab[idx].fim) begin
          n_fail++;
          $display("FAIL vec k=%0d: got lin=%h col=%h eq=%0d el=%0d fim=%b required lin=%h col=%h eq=%0d el=%0d fim=%b",
                   k, linhas, colunas, end_quadro, end_linha, fim_quadro,
                   tab[idx].linhas, tab[idx].colunas, tab[idx].eq, tab[idx].el, tab[idx].fim);
        end else begin
          $display("[TB] ok vec k=%0d lin=%h col=%h eq=%0d el=%0d fim=%b",
                   k, linhas, colunas, end_quadro, end_linha, fim_quadro);
        end
        idx++;
      end
    end

    // Mode 10: auto-advance every 2 frames with wrap 2 -> 0
    chaves = 2'b10;
    for (int p = 0; p < 6; p++) begin
      wait_fim($sformatf("auto pulse %0d", p + 1));
      chk($sformatf("auto eq after pulse %0d", p + 1), {5'b0, end_quadro}, {5'b0, exp10[p]});
      if (p == 0) begin
        step(1);
        chk("fim one cycle", {7'b0, fim_quadro}, 8'h00);
      end
    end

    // Mode 11: manual stepping
    reset  = 1'b1;
    chaves = 2'b11;
    step(2);
    reset = 1'b0;
    step(18);
    botao = 1'b1;
    step(1);
    botao = 1'b0;
    step(1);
    botao = 1'b1;
    step(1);
    botao = 1'b0;
    step(30);
    chk("manual eq before boundary", {5'b0, end_quadro}, 8'h00);
    wait_fim("manual frame 0");
    chk("manual eq one step", {5'b0, end_quadro}, 8'h01);
    wait_fim("manual frame 1");
    chk("manual no press no step", {5'b0, end_quadro}, 8'h01);
    chaves = 2'b01;
    step(5);
    botao = 1'b1;
    step(2);
    botao = 1'b0;
    step(10);
    chaves = 2'b11;
    wait_fim("manual frame 2");
    chk("press in 01 ignored", {5'b0, end_quadro}, 8'h01);
    step(5);
    botao = 1'b1;
    step(2);
    botao = 1'b0;
    wait_fim("manual frame 3");
    chk("manual second step", {5'b0, end_quadro}, 8'h02);

    // Switch off during row 4 display, then back on
    step(29);
    chaves = 2'b00;
    step(2);
    chk("row4 still lit", {1'b0, linhas}, 8'h6F);
    chk("row4 colunas", {3'b0, colunas}, 8'h0B);
    step(1);
    chk("off linhas", {1'b0, linhas}, 8'h7F);
    chk("off colunas", {3'b0, colunas}, 8'h1F);
    chk("off end_quadro kept", {5'b0, end_quadro}, 8'h02);
    chk("off end_linha", {5'b0, end_linha}, 8'h00);
    step(3);
    chaves = 2'b01;
    step(3);
    chk("restart carrega", {1'b0, linhas}, 8'h7F);
    chk("restart end_linha", {5'b0, end_linha}, 8'h00);
    step(1);
    chk("restart row0", {1'b0, linhas}, 8'h7E);
    chk("restart colunas", {3'b0, colunas}, 8'h0F);

    // Asynchronous reset while a row is lit
    #3;
    reset = 1'b1;
    #1;
    chk("async rst linhas", {1'b0, linhas}, 8'h7F);
    chk("async rst colunas", {3'b0, colunas}, 8'h1F);
    chk("async rst end_quadro", {5'b0, end_quadro}, 8'h00);
    chk("async rst end_linha", {5'b0, end_linha}, 8'h00);
    step(1);
    reset = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_varredura_matriz.md
Name: controle_varredura_matriz

Overview:
- Scan controller for the 7x5 LED matrix.
- Sequences row scanning one row at a time, fetches each row's column pattern from an external registered pattern memory, and blanks the display between rows to prevent ghosting.
- Selects the displayed frame (quadro) using the two mode switches: off, fixed, auto-advance, or manual step by button.
- Replaces the free-running divider/counter scan path and drives the matrix row/column pins directly.

Parameters:
- DIV_LINHA, 50000: clock cycles each row is lit (1 ms at 50 MHz).
- APAGA, 500: blanking cycles after each row; all outputs inactive.
- N_QUADROS, 8: number of frames; end_quadro wraps at N_QUADROS-1. Range 1..8.
- QUADROS_AUTO, 100: full frame scans per auto-advance step.

Ports:
- clock_50MHz  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- chaves  input  2  mode switches, asynchronous; 2-FF synchronized. 00 off, 01 fixed, 10 auto, 11 manual.
- botao  input  1  step button, active-high, asynchronous; 2-FF synchronized, rising-edge detected.
- dado_colunas  input  5  pattern for (end_quadro, end_linha); 1 = LED on; valid one cycle after the address changes.
- end_quadro  output  3  frame address to the pattern memory.
- end_linha  output  3  row address to the pattern memory, range 0..6.
- linhas  output  7  row drives, active-low, one-hot; row r drives linhas[r]=0.
- colunas  output  5  column drives, active-low; colunas = ~pattern while lit, 5'h1F otherwise.
- fim_quadro  output  1  one-cycle pulse when the last cycle of row 6 blanking completes.

Behaviour:
- Reset (async, active-high):
  - linhas=7'h7F, colunas=5'h1F, end_quadro=0, end_linha=0, fim_quadro=0.
  - state=DESLIGADO; row counter, frame counter and button-pending flag cleared.
- All outputs are registered.
- FSM states: DESLIGADO, CARREGA, EXIBE, APAGADO.
- DESLIGADO:
  - linhas=7'h7F, colunas=5'h1F, end_linha=0.
  - When synchronized chaves != 00, go to CARREGA at row 0.
- CARREGA:
  - Lasts 1 cycle with end_linha=r, linhas/colunas inactive.
  - Next edge: capture dado_colunas, load colunas=~dado_colunas and linhas=~(1<<r), go to EXIBE.
- EXIBE:
  - Lasts exactly DIV_LINHA cycles.
  - Then linhas=7'h7F, colunas=5'h1F, go to APAGADO.
- APAGADO:
  - Lasts exactly APAGA cycles (APAGA=0 means skip it).
  - Then r=r+1 and go to CARREGA.
  - After row 6: r wraps to 0, fim_quadro pulses and the frame boundary is processed.
- Row period is 1+DIV_LINHA+APAGA cycles; frame period is 7x that.
- Frame boundary rules, using the mode sampled at that boundary:
  - 01: end_quadro held.
  - 10: frame counter increments. When it reaches QUADROS_AUTO it clears and end_quadro advances, wrapping N_QUADROS-1 to 0.
  - 11: if the pending flag is set, end_quadro advances (wrapping) and the flag clears. Only one step per boundary.
- Button:
  - A rising edge sets the pending flag in mode 11 only; in other modes the flag is held cleared.
  - Multiple edges within one frame produce a single step.
  - The edge detector and pending flag share one always block.
- Mode changes:
  - Switching to 00 takes effect on the cycle after the synchronizer output changes. Any state goes to DESLIGADO and outputs are forced inactive that cycle.
  - end_quadro is preserved; the frame counter and pending flag are cleared.
  - Changes among 01/10/11 take effect only at the next frame boundary; a row scan in progress is never truncated.
- end_quadro changes only at frame boundaries, so a frame never mixes patterns.
- At most one linhas bit is low at any time; linhas and colunas are never active during CARREGA or APAGADO.
- Mid-operation reset returns all outputs to reset values immediately (asynchronous).

Test Plan (DIV_LINHA=4, APAGA=2, N_QUADROS=3, QUADROS_AUTO=2; 7-cycle rows, 49-cycle frames; pattern memory model returns {end_quadro[1:0], end_linha[2:0]} registered):
- Reset asserted, chaves=01 -> linhas=7'h7F, colunas=5'h1F, end_quadro=0. After release plus 2 synchronizer cycles plus 1 CARREGA cycle: linhas=7'h7E for exactly 4 cycles, colunas=~5'b00000, then 2 blank cycles.
- Mode 01, 3 frames -> linhas walks 7E,7D,7B,77,6F,5F,3F; fim_quadro pulses every 49 cycles; end_quadro stays 0. Row 3: colunas=~5'b00011.
- Mode 10 -> end_quadro 0->1 after 2 fim_quadro pulses, 1->2 after 4, 2->0 after 6 (wrap).
- Mode 11, two botao pulses during row 2 of frame 0 -> end_quadro=1 only at the next fim_quadro. No further step without a new press. A press in mode 01 followed by a switch to 11 causes no step.
- Switch to 00 during EXIBE of row 4 -> linhas=7'h7F, colunas=5'h1F within 3 cycles, end_quadro unchanged. Return to 01 -> scan restarts at row 0.
- Assert reset during EXIBE -> outputs at reset values in the same cycle, without waiting for a clock edge. Scoreboard checks one-hot-low linhas for the whole run.
